// File: rtl/io_mmio_pkg.sv
// Shared address map and error-bit layout for the memory-mapped I/O unit.
package io_mmio_pkg;
   localparam logic [7:0] IO_LED   = 8'h00;
   localparam logic [7:0] IO_FSTAT = 8'h04;
   localparam logic [7:0] IO_FPUSH = 8'h08;
   localparam logic [7:0] IO_ISTAT = 8'h0C;
   localparam logic [7:0] IO_IDATA = 8'h10;
   localparam logic [7:0] IO_CYC   = 8'h14;
   localparam logic [7:0] IO_ERR   = 8'h18;

   localparam int ERR_OVF = 0;
   localparam int ERR_OVR = 1;

   // CPU accesses are word-aligned; the byte-lane bits never take part in decode.
   function automatic logic [7:0] word_addr(input logic [7:0] a);
      return {a[7:2], 2'b00};
   endfunction
endpackage

// File: rtl/io_mmio_if.sv
// CPU I/O bus plus display-driver handshake; master is the CPU/display side.
interface io_mmio_if;
   logic [7:0]  io_addr;
   logic [31:0] io_dout;
   logic        io_we;
   logic        io_rd;
   logic [31:0] io_din;
   logic [31:0] disp_data;
   logic        disp_valid;
   logic        disp_ready;

   modport master (
      output io_addr, io_dout, io_we, io_rd, disp_ready,
      input  io_din, disp_data, disp_valid
   );
   modport slave (
      input  io_addr, io_dout, io_we, io_rd, disp_ready,
      output io_din, disp_data, disp_valid
   );
endinterface

// File: rtl/io_debouncer.sv
// Button synchronizer + debounce counter; rise pulses on the cycle the level goes 0->1.
module io_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1, s2, level, hit;
   logic [CW-1:0] cnt;

   // Flip on the edge that would make the count reach DEBOUNCE_CYCLES.
   assign hit  = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign rise = hit && !level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (hit) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/io_mmio_unit.sv
// MMIO unit: LED register, debounced switch latch, display output FIFO,
// cycle counter and sticky error flags behind the CPU io_* port.
module io_mmio_unit
   import io_mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4   // power of two, >= 2
) (
   input  logic        clk,
   input  logic        rst_n,
   io_mmio_if.slave    bus,
   input  logic [15:0] sw,
   input  logic        btn_in,
   output logic [15:0] led
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [15:0]   sw_s1, sw_s2, idata;
   logic          ivalid;
   logic [1:0]    err, err_set;
   logic [31:0]   cyc;
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic [7:0]    waddr;
   logic          full, empty, push, pop, accept, ovf, rise, rd_idata, ovr, err_wr;

   io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in),
      .rise   (rise)
   );

   assign waddr    = word_addr(bus.io_addr);
   assign full     = (count == (PW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign pop      = bus.disp_valid && bus.disp_ready;
   assign push     = bus.io_we && (waddr == IO_FPUSH);
   // A push into a full FIFO still lands if the head leaves in the same cycle.
   assign accept   = push && (!full || pop);
   assign ovf      = push && full && !pop;
   assign rd_idata = bus.io_rd && (waddr == IO_IDATA);
   assign ovr      = rise && ivalid && !rd_idata;
   assign err_wr   = bus.io_we && (waddr == IO_ERR);

   assign bus.disp_valid = !empty;
   assign bus.disp_data  = empty ? '0 : fifo_mem[head];

   always_comb begin
      err_set          = '0;
      err_set[ERR_OVF] = ovf;
      err_set[ERR_OVR] = ovr;
   end

   always_comb begin
      bus.io_din = '0;
      case (waddr)
         IO_LED:   bus.io_din = {16'b0, led};
         IO_FSTAT: bus.io_din = 32'({count, !full});
         IO_ISTAT: bus.io_din = {31'b0, ivalid};
         IO_IDATA: bus.io_din = {16'b0, idata};
         IO_CYC:   bus.io_din = cyc;
         IO_ERR:   bus.io_din = {30'b0, err};
         default:  bus.io_din = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         led    <= '0;
         idata  <= '0;
         ivalid <= 1'b0;
         err    <= '0;
         cyc    <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         cyc   <= cyc + 32'd1;

         if (bus.io_we && (waddr == IO_LED)) led <= bus.io_dout[15:0];

         // A fresh latch wins over a same-cycle data read, so valid stays set.
         if (rise) begin
            idata  <= sw_s2;
            ivalid <= 1'b1;
         end else if (rd_idata) begin
            ivalid <= 1'b0;
         end

         err <= (err_wr ? (err & ~bus.io_dout[1:0]) : err) | err_set;

         if (accept) begin
            fifo_mem[tail] <= bus.io_dout;
            tail           <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_io_mmio_unit.sv
// Directed bench for io_mmio_unit; stimulus queues expectations, a negedge monitor compares.
module tb_io_mmio_unit;
   import io_mmio_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw;
   logic        btn_in;
   logic [15:0] led;
   logic        probe_en;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd_q [$];
   string       rd_n [$];
   logic [31:0] dq   [$];
   logic [48:0] pr_q [$];
   string       pr_n [$];
   logic [48:0] pe;
   string       pn;

   io_mmio_if bus ();

   io_mmio_unit #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .sw     (sw),
      .btn_in (btn_in),
      .led    (led)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // Monitor: the only process that compares or touches the counters.
   always @(negedge clk) begin
      if (bus.io_rd) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got read of %h expected none", bus.io_addr);
         end else begin
            pn = rd_n.pop_front();
            cmp(pn, bus.io_din, rd_q.pop_front());
         end
      end
      if (rst_n && bus.disp_valid && bus.disp_ready) begin
         if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL disp_unexpected: got %h expected no pop", bus.disp_data);
         end else begin
            cmp("disp_data", bus.disp_data, dq.pop_front());
         end
      end
      if (probe_en) begin
         pe = pr_q.pop_front();
         pn = pr_n.pop_front();
         cmp({pn, "_led"}, 32'(led), 32'(pe[48:33]));
         cmp({pn, "_dvalid"}, 32'(bus.disp_valid), 32'(pe[32]));
         cmp({pn, "_ddata"}, bus.disp_data, pe[31:0]);
      end
      if (done) begin
         checks++;
         if (rd_q.size() != 0 || dq.size() != 0 || pr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got rd=%0d disp=%0d probe=%0d pending expected 0",
                     rd_q.size(), dq.size(), pr_q.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.io_addr = a; bus.io_dout = d; bus.io_we = 1'b1;
      tick();
      bus.io_we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
      bus.io_addr = a; bus.io_rd = 1'b1;
      rd_q.push_back(e); rd_n.push_back(n);
      tick();
      bus.io_rd = 1'b0;
   endtask

   task automatic probe(input logic [15:0] l, input logic v, input logic [31:0] d, input string n);
      pr_q.push_back({l, v, d}); pr_n.push_back(n);
      probe_en = 1'b1;
      tick();
      probe_en = 1'b0;
   endtask

   task automatic press(input logic [15:0] s);
      sw = s; btn_in = 1'b1; idle(8);
      btn_in = 1'b0; idle(8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no summary by 200000 expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sw = '0; btn_in = 1'b0; probe_en = 1'b0; done = 1'b0;
      bus.io_addr = '0; bus.io_dout = '0; bus.io_we = 1'b0; bus.io_rd = 1'b0;
      bus.disp_ready = 1'b0;
      tick();
      repeat (6) begin
         sw = 16'($urandom); btn_in = 1'($urandom); bus.io_dout = $urandom;
         bus.io_addr = 8'($urandom); bus.disp_ready = 1'($urandom); bus.io_we = 1'($urandom);
         tick();
      end
      bus.io_we = 1'b0; bus.disp_ready = 1'b0;
      probe(16'h0, 1'b0, 32'h0, "rst_out");
      rd(IO_FSTAT, 32'h1, "rst_fstat");
      rd(IO_ISTAT, 32'h0, "rst_istat");
      rd(IO_ERR,   32'h0, "rst_err");
      rd(IO_CYC,   32'h0, "rst_cyc");
      sw = '0; btn_in = 1'b0; bus.io_dout = '0;
      rst_n = 1'b1;
      rd(IO_CYC, 32'd0, "cyc0");
      rd(IO_CYC, 32'd1, "cyc1");
      rd(IO_CYC, 32'd2, "cyc2");

      // LED register and decode
      wr(IO_LED, 32'h0001ABCD);
      probe(16'hABCD, 1'b0, 32'h0, "led_out");
      rd(IO_LED, 32'h0000ABCD, "led_rd");
      rd(8'h03,  32'h0000ABCD, "led_rd_lowbits");
      wr(8'h1C, 32'hFFFFFFFF);
      rd(8'h1C, 32'h0, "unmapped_rd");
      rd(IO_FSTAT, 32'h1, "unmapped_no_push");

      // Bouncy button never qualifies
      for (int i = 0; i < 10; i++) begin
         btn_in = ~btn_in;
         idle(2);
      end
      rd(IO_ISTAT, 32'h0, "bounce_valid");
      idle(4);

      // Clean press: valid after edge 6
      sw = 16'h1234; btn_in = 1'b1;
      idle(5);
      rd(IO_ISTAT, 32'h0, "deb_edge5");
      rd(IO_ISTAT, 32'h1, "deb_edge6");
      rd(IO_IDATA, 32'h1234, "deb_data");
      rd(IO_ISTAT, 32'h0, "deb_cleared");
      btn_in = 1'b0;
      idle(8);

      // FIFO overflow and drain
      wr(IO_FPUSH, 32'd1);
      probe(16'hABCD, 1'b1, 32'd1, "push_lat");
      for (int d = 2; d <= 5; d++) wr(IO_FPUSH, 32'(d));
      probe(16'hABCD, 1'b1, 32'd1, "hold_head");
      rd(IO_FSTAT, 32'h8, "fstat_full");
      rd(IO_ERR,   32'h1, "err_ovf");
      for (int d = 1; d <= 4; d++) dq.push_back(32'(d));
      bus.disp_ready = 1'b1;
      idle(4);
      probe(16'hABCD, 1'b0, 32'h0, "drained");
      wr(IO_ERR, 32'h1);
      rd(IO_ERR, 32'h0, "err_ovf_clr");

      // Full FIFO: push with simultaneous pop is accepted
      bus.disp_ready = 1'b0;
      for (int d = 5; d <= 8; d++) wr(IO_FPUSH, 32'(d));
      rd(IO_FSTAT, 32'h8, "fstat_full2");
      for (int d = 5; d <= 9; d++) dq.push_back(32'(d));
      bus.disp_ready = 1'b1;
      wr(IO_FPUSH, 32'd9);
      rd(IO_ERR, 32'h0, "no_ovf");
      idle(4);
      rd(IO_FSTAT, 32'h1, "fstat_empty");
      bus.disp_ready = 1'b0;

      // Overrun: two presses without a read
      press(16'h00AA);
      press(16'h5555);
      rd(IO_ISTAT, 32'h1, "ovr_valid");
      rd(IO_ERR,   32'h2, "err_ovr");
      wr(IO_ERR, 32'h0);
      rd(IO_ERR,   32'h2, "err_w0_keeps");
      rd(IO_IDATA, 32'h5555, "ovr_data");
      wr(IO_ERR, 32'h2);
      rd(IO_ERR,   32'h0, "err_ovr_clr");
      rd(IO_ISTAT, 32'h0, "ovr_valid_clr");

      // Latch event coinciding with a data read
      press(16'h0F0F);
      sw = 16'h7777; btn_in = 1'b1;
      idle(5);
      rd(IO_IDATA, 32'h0F0F, "coinc_old");
      rd(IO_ISTAT, 32'h1, "coinc_valid");
      rd(IO_ERR,   32'h0, "coinc_no_ovr");
      rd(IO_IDATA, 32'h7777, "coinc_new");
      rd(IO_ISTAT, 32'h0, "coinc_clr");
      btn_in = 1'b0;
      idle(2);
      done = 1'b1;
      idle(2);
   end
endmodule

// File: doc/io_mmio_unit.md
# io_mmio_unit

Memory-mapped I/O unit on the CPU's `io_*` port, decoding the CPU's word-aligned I/O accesses from its memory stage. It holds the LED register and a debounced-button input latch that captures the switches. It has a 4-deep output FIFO with valid/ready handshake to the display driver, plus a free-running cycle counter and sticky error flags.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required before the debounced button level changes.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two, at least 2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_addr` in 8: byte address from CPU; bits [1:0] ignored.
- `io_dout` in 32: CPU write data.
- `io_we` in 1: CPU write strobe, one cycle per store.
- `io_rd` in 1: CPU read strobe, one cycle per load.
- `io_din` out 32: read data to CPU, combinational from `io_addr`.
- `sw` in 16: raw switches, asynchronous.
- `btn_in` in 1: raw button, asynchronous, bouncy.
- `led` out 16: LED register.
- `disp_data` out 32: FIFO head entry.
- `disp_valid` out 1: FIFO non-empty.
- `disp_ready` in 1: display driver accepts head.

## Operation
- Address map, word offsets:
  - 0x00 R/W: LED; write loads `io_dout[15:0]`; read returns {16'b0, led}.
  - 0x04 R: bit0 = FIFO not full; bits[3:1] = entry count (FIFO_DEPTH=4 fits).
  - 0x08 W: push `io_dout` into FIFO.
  - 0x0C R: bit0 = input valid.
  - 0x10 R: {16'b0, latched sw}; `io_rd` here clears valid at the clock edge.
  - 0x14 R: 32-bit cycle counter, +1 every cycle, wraps 0xFFFFFFFF→0.
  - 0x18 R/W: sticky errors; bit0 = FIFO overflow, bit1 = input overrun; a write of 1 clears the bit, a write of 0 leaves it.
- Any other address: reads 0, writes ignored. Reads other than 0x10 have no side effects.
- Button path:
  - `btn_in` and `sw` each pass through a 2-flop synchronizer.
  - A debounce counter advances while the synchronized button differs from the debounced level and resets to 0 when they match.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter resets.
  - A debounced 0→1 transition latches synchronized `sw` and sets valid.
- Overrun: a latch event while valid is already 1 overwrites the data, keeps valid at 1 and sets error bit1.
- Latch event and 0x10 read in the same cycle: new data latched, valid stays 1, no overrun.
- FIFO:
  - Pop occurs when `disp_valid & disp_ready`.
  - A push when not full is accepted.
  - A push when full is accepted only if a pop occurs in the same cycle (count unchanged); otherwise it is dropped and error bit0 is set.
  - Simultaneous push and pop when non-empty leaves the count unchanged.
  - `disp_data` is 0 when the FIFO is empty.
- `io_we` and `io_rd` are never both asserted; if both are, the write takes effect and the read side effect also applies.

## Timing
- Reset (asynchronous, while `rst_n`=0): `led`=0, `disp_valid`=0, `disp_data`=0, FIFO count 0 and pointers 0, valid=0, latched sw=0, errors=0, counter=0, synchronizers 0, debounced level 0.
- `io_din` is combinational with zero latency; register updates are visible the cycle after the strobe.
- Button response: with `btn_in` high and stable from before edge 1, valid and the latched data are visible after edge DEBOUNCE_CYCLES+2 (edge 6 at the default).
- A release needs DEBOUNCE_CYCLES+2 edges of stable low before the next press is recognized.
- Push-to-`disp_valid` latency is 1 cycle. `disp_data` is stable while `disp_valid` is high and `disp_ready` is low.
- A FIFO pointer wraps from FIFO_DEPTH-1 to 0.
- Reset asserted mid-debounce or mid-handshake discards all state immediately.

## Structure
- Package `io_mmio_pkg`:
  - address constants `IO_LED`, `IO_FSTAT`, `IO_FPUSH`, `IO_ISTAT`, `IO_IDATA`, `IO_CYC`, `IO_ERR`;
  - error bit indices.
- Sub-module `io_debouncer`: synchronizer, counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES.
- The FIFO is inline: register array, head/tail pointers, count.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. Requires `led`=0, `disp_valid`=0, reads of 0x04=0x1, 0x0C=0, 0x18=0, 0x14=0; after release, 0x14 increments by 1 per cycle.
- LED: write 0x0001ABCD to 0x00. Requires `led`=0xABCD next cycle and a read of 0x00 returning 0x0000ABCD.
- Debounce:
  - Toggle `btn_in` every 2 cycles for 20 cycles: valid stays 0.
  - Then hold high with `sw`=0x1234: valid rises after 6 edges; a read of 0x10 returns 0x1234 and the next read of 0x0C returns 0.
- FIFO overflow: hold `disp_ready`=0 and push 1..5. Requires 0x04=0x8 (count 4, not-full 0) and 0x18 bit0 set. Then `disp_ready`=1 yields `disp_data` 1,2,3,4 on consecutive cycles, then `disp_valid`=0.
- Full push+pop: with the FIFO full and `disp_ready`=1, push 9. Requires no overflow and 9 emerging after the 3 remaining entries.
- Overrun and clear: two debounced presses without reading. Requires 0x18=0x2 and the second `sw` value latched; writing 0x2 to 0x18 makes it read 0.
